// File: rtl/mod_n_seq_checker.sv
// Receive-side integrity monitor for a mod-N counter stream: locks onto the
// ascending 0..N-1 wrap sequence and flags skipped, repeated or out-of-range values.
module mod_n_seq_checker #(
    parameter int N        = 6,
    parameter int W        = 3,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     in_count,
    output logic             locked,
    output logic [W-1:0]     expected,
    output logic             err_pulse,
    output logic             illegal_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int            MW    = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0]  LAST  = W'(N - 1);
    localparam logic [W:0]    LIMIT = (W + 1)'(N);
    localparam logic [MW-1:0] LOCK  = MW'(LOCK_CNT);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] match, match_nxt, match_inc;
    logic [W-1:0]  expected_nxt, seed;
    logic          illegal, accepted, hit;
    logic          err_nxt, illegal_nxt, wrap_nxt;

    // Compared at W+1 bits so N == 2^W still fits.
    assign illegal   = in_valid && ({1'b0, in_count} >= LIMIT);
    assign accepted  = in_valid && !illegal;
    assign seed      = (in_count == LAST) ? '0 : in_count + W'(1);
    assign hit       = (in_count == expected);
    assign match_inc = match + MW'(1);

    always_comb begin
        state_nxt    = state;
        match_nxt    = match;
        expected_nxt = expected;
        err_nxt      = 1'b0;
        illegal_nxt  = 1'b0;
        wrap_nxt     = 1'b0;
        if (illegal) begin
            // Out-of-range value: drop lock but keep the last good expectation.
            illegal_nxt = 1'b1;
            state_nxt   = HUNT;
            match_nxt   = '0;
        end else if (accepted) begin
            expected_nxt = seed;
            case (state)
                HUNT: begin
                    state_nxt = SYNC;
                    match_nxt = '0;
                end
                SYNC: begin
                    if (hit) begin
                        match_nxt = match_inc;
                        if (match_inc == LOCK) state_nxt = LOCKED;
                    end else begin
                        match_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        wrap_nxt = (in_count == '0);
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                        match_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    match_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HUNT;
            match         <= '0;
            expected      <= '0;
            err_pulse     <= 1'b0;
            illegal_pulse <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            match         <= match_nxt;
            expected      <= expected_nxt;
            err_pulse     <= err_nxt;
            illegal_pulse <= illegal_nxt;
            wrap_pulse    <= wrap_nxt;
        end
    end

    // Saturating count; pulses keep firing once it pins at all-ones.
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if ((err_nxt || illegal_nxt) && (err_count != '1))
            err_count <= err_count + ERR_W'(1);
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// Directed bench for mod_n_seq_checker: default instance plus an ERR_W=2 copy
// sharing the same stimulus for the saturation case.
module tb_mod_n_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_count = '0;

    logic       locked, err_pulse, illegal_pulse, wrap_pulse;
    logic [2:0] expected;
    logic [7:0] err_count;

    logic       s_locked, s_err_pulse, s_illegal_pulse, s_wrap_pulse;
    logic [2:0] s_expected;
    logic [1:0] s_err_count;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_n_seq_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_count(in_count),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .illegal_pulse(illegal_pulse), .wrap_pulse(wrap_pulse), .err_count(err_count)
    );

    mod_n_seq_checker #(.N(6), .W(3), .LOCK_CNT(3), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_count(in_count),
        .locked(s_locked), .expected(s_expected), .err_pulse(s_err_pulse),
        .illegal_pulse(s_illegal_pulse), .wrap_pulse(s_wrap_pulse), .err_count(s_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample on the falling edge, return #1 after the capturing edge.
    task automatic send(input logic v, input logic [2:0] c);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = v;
        in_count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic rst(input logic v, input logic [2:0] c);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = v;
        in_count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic l, input logic [2:0] e,
                           input logic ep, input logic ip, input logic wp, input logic [7:0] ec);
        chk({tag, ".locked"},   locked,        l);
        chk({tag, ".expected"}, expected,      e);
        chk({tag, ".err"},      err_pulse,     ep);
        chk({tag, ".illegal"},  illegal_pulse, ip);
        chk({tag, ".wrap"},     wrap_pulse,    wp);
        chk({tag, ".err_count"}, err_count,    ec);
    endtask

    initial begin
        // Reset wins over a concurrent valid sample (3 would seed expected=4).
        rst(1'b1, 3'd3);
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        // Lock and wrap: 2 seeds, 3/4/5 are three matches.
        send(1, 2); chk_all("lk2", 0, 3, 0, 0, 0, 0);
        send(1, 3); chk_all("lk3", 0, 4, 0, 0, 0, 0);
        send(1, 4); chk_all("lk4", 0, 5, 0, 0, 0, 0);
        send(1, 5); chk_all("lk5", 1, 0, 0, 0, 0, 0);
        send(1, 0); chk_all("wrap0", 1, 1, 0, 0, 1, 0);
        send(1, 1); chk_all("lk1", 1, 2, 0, 0, 0, 0);

        // Skip error 2 -> 4, then relock: 5 seeds, 0/1/2 match.
        send(1, 2); chk_all("sk2", 1, 3, 0, 0, 0, 0);
        send(1, 4); chk_all("skip", 0, 5, 1, 0, 0, 1);
        send(1, 5); chk_all("rl5", 0, 0, 0, 0, 0, 1);
        send(1, 0); chk_all("rl0", 0, 1, 0, 0, 0, 1);
        send(1, 1); chk_all("rl1", 0, 2, 0, 0, 0, 1);
        send(1, 2); chk_all("rl2", 1, 3, 0, 0, 0, 1);

        // Illegal while locked, then illegal while in SYNC; expected is held.
        send(1, 6); chk_all("ill6", 0, 3, 0, 1, 0, 2);
        send(1, 3); chk_all("hunt3", 0, 4, 0, 0, 0, 2);
        send(1, 7); chk_all("ill7", 0, 4, 0, 1, 0, 3);
        // Back in HUNT: 4 seeds; a SYNC mismatch restarts matching without counting.
        send(1, 4); chk_all("h4", 0, 5, 0, 0, 0, 3);
        send(1, 5); chk_all("s5", 0, 0, 0, 0, 0, 3);
        send(1, 2); chk_all("smis", 0, 3, 0, 0, 0, 3);
        send(1, 3); chk_all("s3", 0, 4, 0, 0, 0, 3);
        send(1, 4); chk_all("s4", 0, 5, 0, 0, 0, 3);
        send(1, 5); chk_all("s5lk", 1, 0, 0, 0, 0, 3);

        // Gaps: an out-of-range value with in_valid low must be ignored.
        send(1, 0); chk_all("g0", 1, 1, 0, 0, 1, 3);
        send(1, 1); send(1, 2); send(1, 3);
        send(1, 4); chk_all("g4", 1, 5, 0, 0, 0, 3);
        for (int i = 0; i < 5; i++) begin
            send(0, 7); chk_all("gap", 1, 5, 0, 0, 0, 3);
        end
        send(1, 5); chk_all("g5", 1, 0, 0, 0, 0, 3);
        send(1, 0); chk_all("gwrap", 1, 1, 0, 0, 1, 3);

        // Upstream reset: locked at 3, jump to 0.
        send(1, 1); send(1, 2);
        send(1, 3); chk_all("u3", 1, 4, 0, 0, 0, 3);
        send(1, 0); chk_all("ujump", 0, 1, 1, 0, 0, 4);
        send(1, 1); chk_all("u1", 0, 2, 0, 0, 0, 4);
        send(1, 2); send(1, 3); chk_all("u3b", 0, 4, 0, 0, 0, 4);
        send(1, 4); chk_all("urelock", 1, 5, 0, 0, 0, 4);

        // Reset mid-lock: drops lock, no error pulse, count cleared.
        rst(1'b1, 3'd5);
        chk_all("rstlk", 0, 0, 0, 0, 0, 0);

        // Saturation on the ERR_W=2 copy.
        for (int k = 1; k <= 5; k++) begin
            send(1, 7);
            chk("sat.illegal", s_illegal_pulse, 1);
            chk("sat.count", s_err_count, (k > 3) ? 3 : k);
            chk("wide.count", err_count, k);
        end
        rst(1'b1, 3'd0);
        chk("satrst.count",   s_err_count,     0);
        chk("satrst.illegal", s_illegal_pulse, 0);
        chk("satrst.locked",  s_locked,        0);
        chk("satrst.exp",     s_expected,      0);
        chk("satrst.err",     s_err_pulse,     0);
        chk("satrst.wrap",    s_wrap_pulse,    0);

        // First sample after release is a HUNT sample.
        send(1, 1); chk_all("pr1", 0, 2, 0, 0, 0, 0);
        send(1, 2); send(1, 3); chk_all("pr3", 0, 4, 0, 0, 0, 0);
        send(1, 4); chk_all("pr4", 1, 5, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
